// File: rtl/next_pc_bpu_if.sv
// Fetch-side bus of the next-PC / branch-prediction block: fetch inputs, EX
// resolution feedback, and the PC / prediction / flush results.
interface next_pc_bpu_if #(
    parameter int CPU_WIDTH = 32
);
    logic                 ena;
    logic [31:0]          if_inst;
    logic                 ex_valid;
    logic                 ex_is_branch;
    logic [CPU_WIDTH-1:0] ex_pc;
    logic                 ex_taken;
    logic [CPU_WIDTH-1:0] ex_target;
    logic                 ex_pred_taken;
    logic [CPU_WIDTH-1:0] pc_o;
    logic                 if_pred_taken;
    logic                 flush_o;
    logic [15:0]          mispred_cnt;

    modport master (
        output ena, if_inst, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target, ex_pred_taken,
        input  pc_o, if_pred_taken, flush_o, mispred_cnt
    );

    modport slave (
        input  ena, if_inst, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target, ex_pred_taken,
        output pc_o, if_pred_taken, flush_o, mispred_cnt
    );
endinterface

// File: rtl/next_pc_bpu.sv
// Next fetch PC selection with static or 2-bit BHT branch prediction,
// EX-stage mispredict redirect/flush and a saturating mispredict counter.
module next_pc_bpu #(
    parameter int                   CPU_WIDTH = 32,
    parameter int                   BHT_DEPTH = 16,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = '0,
    parameter int                   PRED_MODE = 1
) (
    input logic          clk,
    input logic          rst_n,
    next_pc_bpu_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [CPU_WIDTH-1:0] pc_q;
    logic [15:0]          cnt_q;
    logic [6:0]           opcode;
    logic                 is_b, is_jal, is_jalr;
    logic [31:0]          imm_b, imm_j;
    logic [CPU_WIDTH-1:0] imm_b_x, imm_j_x, pred_target, pc_next;
    logic                 bht_taken;
    logic                 pred_taken;
    logic                 mispredict;

    assign opcode  = bus.if_inst[6:0];
    assign is_b    = (opcode == 7'b1100011);
    assign is_jal  = (opcode == 7'b1101111);
    assign is_jalr = (opcode == 7'b1100111);

    assign imm_b = {{20{bus.if_inst[31]}}, bus.if_inst[7], bus.if_inst[30:25],
                    bus.if_inst[11:8], 1'b0};
    assign imm_j = {{12{bus.if_inst[31]}}, bus.if_inst[19:12], bus.if_inst[20],
                    bus.if_inst[30:21], 1'b0};
    assign imm_b_x = CPU_WIDTH'($signed(imm_b));
    assign imm_j_x = CPU_WIDTH'($signed(imm_j));

    assign pred_target = pc_q + (is_jal ? imm_j_x : imm_b_x);

    // JALR target is unknown at fetch, so it is always predicted not-taken.
    always_comb begin
        pred_taken = 1'b0;
        if (is_jal)
            pred_taken = 1'b1;
        else if (is_jalr)
            pred_taken = 1'b0;
        else if (is_b)
            pred_taken = (PRED_MODE == 0) ? bus.if_inst[31] : bht_taken;
    end

    assign mispredict = bus.ena & bus.ex_valid & (bus.ex_taken != bus.ex_pred_taken);

    always_comb begin
        pc_next = pc_q + CPU_WIDTH'(4);
        if (mispredict)
            pc_next = bus.ex_taken ? bus.ex_target : bus.ex_pc + CPU_WIDTH'(4);
        else if (pred_taken)
            pc_next = pred_target;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= {RESET_PC[CPU_WIDTH-1:2], 2'b00};
            cnt_q <= '0;
        end else if (bus.ena) begin
            pc_q <= {pc_next[CPU_WIDTH-1:2], 2'b00};
            if (mispredict && cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
        end
    end

    generate
        if (PRED_MODE == 1) begin : g_bht
            logic [1:0]       bht [BHT_DEPTH];
            logic [IDX_W-1:0] rd_idx, wr_idx;

            assign rd_idx    = pc_q[IDX_W+1:2];
            assign wr_idx    = bus.ex_pc[IDX_W+1:2];
            assign bht_taken = bht[rd_idx][1];

            // Lookup is combinational off the array, so a same-cycle update is not seen.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < BHT_DEPTH; k++)
                        bht[k] <= 2'b01;
                end else if (bus.ena && bus.ex_valid && bus.ex_is_branch) begin
                    if (bus.ex_taken) begin
                        if (bht[wr_idx] != 2'b11)
                            bht[wr_idx] <= bht[wr_idx] + 2'b01;
                    end else begin
                        if (bht[wr_idx] != 2'b00)
                            bht[wr_idx] <= bht[wr_idx] - 2'b01;
                    end
                end
            end
        end else begin : g_no_bht
            assign bht_taken = 1'b0;
        end
    endgenerate

    assign bus.pc_o          = pc_q;
    assign bus.if_pred_taken = pred_taken;
    assign bus.flush_o       = mispredict;
    assign bus.mispred_cnt   = cnt_q;
endmodule
